// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the receive core and the upcoming transmit core.
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE,
      PARITY_ODD,
      PARITY_EVEN
   } parity_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_e;

   // Clocks per oversampling tick, rounded to nearest; 0 flags an unusable setting.
   function automatic int baud_div(input longint clk_freq, input longint baud, input longint os);
      longint den;
      den = baud * os;
      if (den <= 0) return 0;
      return int'((clk_freq + den / 2) / den);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick source: a reloading down-counter emitting a one-cycle tick every DIV clocks.
module uart_baud_gen #(
   parameter int DIV = 27
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic restart,
   output logic tick
);

   localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   if (DIV < 1) begin : g_bad_div
      $error("uart_baud_gen: DIV must be at least 1");
   end

   // Restart realigns the tick phase so the first tick lands a full DIV after the event.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (restart) begin
         cnt  <= RELOAD;
         tick <= 1'b0;
      end else if (cnt == '0) begin
         cnt  <= RELOAD;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt - 1'b1;
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver with majority-vote sampling and a valid/ready output stage.
//
//  state        | meaning
//  RX_IDLE      | line idle, watching for a falling edge
//  RX_START     | validating the start bit (majority 1 = false start)
//  RX_DATA      | shifting in DATA_BITS bits, LSB first
//  RX_PARITY    | sampling and checking the parity bit
//  RX_STOP      | sampling STOP_BITS stop bits
//  RX_WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int      CLK_FREQ   = 50_000_000,
   parameter int      BAUD_RATE  = 115200,
   parameter int      DATA_BITS  = 8,
   parameter parity_e PARITY     = PARITY_NONE,
   parameter int      STOP_BITS  = 1,
   parameter int      OVERSAMPLE = 16
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic                 uart_rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err,
   output logic                 rx_overrun
);

   localparam int DIV    = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
   localparam int TW     = $clog2(OVERSAMPLE);
   localparam bit PAR_EN = (PARITY != PARITY_NONE);

   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] T_S2   = TW'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

   if (DIV < 1 || DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
       OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_param
      $error("uart_rx_core: parameter out of range");
   end

   rx_state_e state, state_nxt;

   logic                 rx_meta, rx_sync, rx_prev;
   logic                 fall;
   logic                 restart, tick;
   logic [TW-1:0]        tick_cnt;
   logic                 samp0, samp1, maj, bit_done;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 frame_err_q, parity_err_q;
   logic                 frame_done, frame_err_fin;
   logic                 ones_odd, par_mismatch;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   assign fall = rx_prev & ~rx_sync;

   uart_baud_gen #(.DIV(DIV)) u_baud_gen (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .restart (restart),
      .tick    (tick)
   );

   // Tick index within the current bit; restarted with the generator on the start edge.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tick_cnt <= '0;
         samp0    <= 1'b0;
         samp1    <= 1'b0;
      end else if (restart) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
         if (tick_cnt == T_S0) samp0 <= rx_sync;
         if (tick_cnt == T_S1) samp1 <= rx_sync;
      end
   end

   assign bit_done = tick && (tick_cnt == T_S2);
   assign maj      = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);

   assign ones_odd     = (^shift_reg) ^ maj;
   assign par_mismatch = (PARITY == PARITY_ODD)  ? ~ones_odd :
                         (PARITY == PARITY_EVEN) ?  ones_odd : 1'b0;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= RX_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      restart       = 1'b0;
      frame_done    = 1'b0;
      frame_err_fin = frame_err_q;
      case (state)
         RX_IDLE: begin
            if (fall) begin
               restart   = 1'b1;
               state_nxt = RX_START;
            end
         end
         RX_START: begin
            if (bit_done) state_nxt = maj ? RX_IDLE : RX_DATA;
         end
         RX_DATA: begin
            if (bit_done && bit_cnt == LAST_DATA) state_nxt = PAR_EN ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: begin
            if (bit_done) state_nxt = RX_STOP;
         end
         RX_STOP: begin
            if (bit_done && bit_cnt == LAST_STOP) begin
               frame_done    = 1'b1;
               frame_err_fin = frame_err_q | ~maj;
               state_nxt     = frame_err_fin ? RX_WAIT_IDLE : RX_IDLE;
            end
         end
         RX_WAIT_IDLE: begin
            if (rx_sync) state_nxt = RX_IDLE;
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   // bit_cnt is reused for data and stop bits, cleared on every state change.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         bit_cnt      <= '0;
         shift_reg    <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else if (restart) begin
         bit_cnt      <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else if (bit_done) begin
         bit_cnt <= (state_nxt != state) ? '0 : bit_cnt + 1'b1;
         if (state == RX_DATA)   shift_reg    <= {maj, shift_reg[DATA_BITS-1:1]};
         if (state == RX_PARITY) parity_err_q <= par_mismatch;
         if (state == RX_STOP && !maj) frame_err_q <= 1'b1;
      end
   end

   // A completed frame loads only if the slot is free or being emptied this cycle.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
         rx_overrun    <= 1'b0;
      end else begin
         rx_overrun <= frame_done && rx_valid && !rx_ready;
         if (frame_done && (!rx_valid || rx_ready)) begin
            rx_data       <= shift_reg;
            rx_valid      <= 1'b1;
            rx_frame_err  <= frame_err_fin;
            rx_parity_err <= PAR_EN & parity_err_q;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: four instances exercised in parallel on independent lines.
module tb_uart_rx_core;
   import uart_pkg::*;

   localparam realtime BIT_T = 8681ns;

   typedef struct packed {
      logic [8:0] data;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       sys_clk;
   logic       sys_rst;
   logic [3:0] line;
   logic [3:0] ready;
   logic [3:0] valid, fe, pe, ovr;
   logic [7:0] d0, d1, d2;
   logic [6:0] d3;
   logic [8:0] data [4];

   int total = 0;
   int bad   = 0;
   int vld_cnt [4] = '{0, 0, 0, 0};
   int ovr_cnt [4] = '{0, 0, 0, 0};
   exp_t q0[$], q1[$], q2[$], q3[$];

   assign data[0] = {1'b0, d0};
   assign data[1] = {1'b0, d1};
   assign data[2] = {1'b0, d2};
   assign data[3] = {2'b00, d3};

   uart_rx_core u_dut0 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(line[0]), .rx_data(d0),
      .rx_valid(valid[0]), .rx_ready(ready[0]), .rx_frame_err(fe[0]),
      .rx_parity_err(pe[0]), .rx_overrun(ovr[0]));

   uart_rx_core u_dut1 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(line[1]), .rx_data(d1),
      .rx_valid(valid[1]), .rx_ready(ready[1]), .rx_frame_err(fe[1]),
      .rx_parity_err(pe[1]), .rx_overrun(ovr[1]));

   uart_rx_core #(.PARITY(PARITY_EVEN)) u_dut2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(line[2]), .rx_data(d2),
      .rx_valid(valid[2]), .rx_ready(ready[2]), .rx_frame_err(fe[2]),
      .rx_parity_err(pe[2]), .rx_overrun(ovr[2]));

   uart_rx_core #(.DATA_BITS(7), .PARITY(PARITY_ODD), .STOP_BITS(2)) u_dut3 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(line[3]), .rx_data(d3),
      .rx_valid(valid[3]), .rx_ready(ready[3]), .rx_frame_err(fe[3]),
      .rx_parity_err(pe[3]), .rx_overrun(ovr[3]));

   initial sys_clk = 1'b0;
   always #10ns sys_clk = ~sys_clk;

   function automatic void push_exp(input int ch, input logic [8:0] d, input logic f, input logic p);
      exp_t e;
      e.data = d;
      e.fe   = f;
      e.pe   = p;
      case (ch)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         2:       q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endfunction

   function automatic int q_len(input int ch);
      case (ch)
         0:       return q0.size();
         1:       return q1.size();
         2:       return q2.size();
         default: return q3.size();
      endcase
   endfunction

   function automatic exp_t q_pop(input int ch);
      case (ch)
         0:       return q0.pop_front();
         1:       return q1.pop_front();
         2:       return q2.pop_front();
         default: return q3.pop_front();
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_frame(input int ch, input logic [8:0] d, input int nbits,
                             input bit has_par, input logic par_bit, input int nstop);
      line[ch] = 1'b0;
      #(BIT_T);
      for (int i = 0; i < nbits; i++) begin
         line[ch] = d[i];
         #(BIT_T);
      end
      if (has_par) begin
         line[ch] = par_bit;
         #(BIT_T);
      end
      line[ch] = 1'b1;
      #(BIT_T * nstop);
   endtask

   // Monitor: every handshake pops one expected frame and compares data and flags.
   always @(negedge sys_clk) begin : mon
      exp_t e;
      for (int c = 0; c < 4; c++) begin
         if (!sys_rst && valid[c]) vld_cnt[c]++;
         if (!sys_rst && ovr[c])   ovr_cnt[c]++;
         if (!sys_rst && valid[c] && ready[c]) begin
            total++;
            if (q_len(c) == 0) begin
               bad++;
               $display("FAIL unexpected_frame ch%0d: got data=%0h fe=%0b pe=%0b expected no frame",
                        c, data[c], fe[c], pe[c]);
            end else begin
               e = q_pop(c);
               if ({data[c], fe[c], pe[c]} !== e) begin
                  bad++;
                  $display("FAIL frame ch%0d: got data=%0h fe=%0b pe=%0b expected data=%0h fe=%0b pe=%0b",
                           c, data[c], fe[c], pe[c], e.data, e.fe, e.pe);
               end
            end
         end
      end
   end

   initial begin
      string hello;
      hello   = "Hello, world!";
      sys_rst = 1'b1;
      line    = 4'hF;
      ready   = 4'hF;
      #100ns;
      sys_rst = 1'b0;
      @(negedge sys_clk);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("rst_valid_ch%0d", c), 32'(valid[c]), 0);
         chk($sformatf("rst_data_ch%0d", c), 32'(data[c]), 0);
         chk($sformatf("rst_flags_ch%0d", c), 32'({fe[c], pe[c], ovr[c]}), 0);
      end

      // Abort a frame with reset partway through; nothing may be delivered.
      line[0] = 1'b0; #(BIT_T);
      line[0] = 1'b1; #(BIT_T);
      line[0] = 1'b0; #(BIT_T);
      line[0] = 1'b0; #(BIT_T);
      sys_rst = 1'b1;
      line[0] = 1'b1;
      #100ns;
      sys_rst = 1'b0;
      #(BIT_T * 12);
      chk("abort_no_frame", 32'(vld_cnt[0]), 0);
      push_exp(0, 9'h041, 1'b0, 1'b0);
      send_frame(0, 9'h041, 8, 1'b0, 1'b0, 1);

      fork
         begin
            for (int i = 0; i < 13; i++) begin
               push_exp(0, {1'b0, hello[i]}, 1'b0, 1'b0);
               send_frame(0, {1'b0, hello[i]}, 8, 1'b0, 1'b0, 1);
            end
         end
         begin
            ready[1] = 1'b0;
            push_exp(1, 9'h048, 1'b0, 1'b0);
            send_frame(1, 9'h048, 8, 1'b0, 1'b0, 1);
            send_frame(1, 9'h069, 8, 1'b0, 1'b0, 1);
            #(BIT_T);
            chk("overrun_pulses", 32'(ovr_cnt[1]), 1);
            chk("overrun_keeps_data", 32'(data[1]), 32'h48);
            chk("overrun_keeps_valid", 32'(valid[1]), 1);
            @(posedge sys_clk); #1ns;
            ready[1] = 1'b1;
            @(posedge sys_clk); #1ns;
            ready[1] = 1'b0;
            chk("valid_drops_after_accept", 32'(valid[1]), 0);
            ready[1] = 1'b1;
            line[1] = 1'b0;
            #2000ns;
            line[1] = 1'b1;
            #(BIT_T * 2);
            push_exp(1, 9'h03C, 1'b0, 1'b0);
            send_frame(1, 9'h03C, 8, 1'b0, 1'b0, 1);
            push_exp(1, 9'h000, 1'b1, 1'b0);
            line[1] = 1'b0;
            #(BIT_T * 20);
            line[1] = 1'b1;
            #(BIT_T * 2);
            push_exp(1, 9'h055, 1'b0, 1'b0);
            send_frame(1, 9'h055, 8, 1'b0, 1'b0, 1);
         end
         begin
            push_exp(2, 9'h041, 1'b0, 1'b0);
            send_frame(2, 9'h041, 8, 1'b1, 1'b0, 1);
            push_exp(2, 9'h041, 1'b0, 1'b1);
            send_frame(2, 9'h041, 8, 1'b1, 1'b1, 1);
         end
         begin
            push_exp(3, 9'h055, 1'b0, 1'b0);
            send_frame(3, 9'h055, 7, 1'b1, 1'b1, 2);
         end
      join

      #(BIT_T * 2);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("pending_frames_ch%0d", c), 32'(q_len(c)), 0);
      end
      chk("valid_cycles_ch0", 32'(vld_cnt[0]), 14);
      chk("valid_cycles_ch2", 32'(vld_cnt[2]), 2);
      chk("valid_cycles_ch3", 32'(vld_cnt[3]), 1);
      chk("no_overrun_ch0", 32'(ovr_cnt[0]), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
